// File: rtl/dm_responder.sv
// ============================================================================
// Module   : dm_responder
// Purpose  : Multi-cycle data-memory responder for the MEM stage of a
//            pipelined MIPS datapath. It accepts word-aligned 32-bit read and
//            write requests, services them after a fixed access latency, and
//            stores bytes in big-endian order.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1   system clock, rising edge
//   rst           in   1   synchronous active-high reset
//   MemAddr       in  32   byte address of the request
//   MemWriteData  in  32   store data
//   MemRead       in   1   read request
//   MemWrite      in   1   write request
//   MemReadData   out 32   load data (registered, held until next read)
//   Mem_Stall     out  1   high while an access is in flight
//   Mem_Done      out  1   one-cycle completion pulse (registered)
//   Mem_Err       out  1   one-cycle rejected-request pulse (registered)
// ============================================================================
`default_nettype none

module dm_responder #(
  parameter int DEPTH_BYTES = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MemAddr,
  input  logic [31:0] MemWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] MemReadData,
  output logic        Mem_Stall,
  output logic        Mem_Done,
  output logic        Mem_Err
);

  localparam int AW = (DEPTH_BYTES > 4) ? $clog2(DEPTH_BYTES) : 2;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            wr_q, wr_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            mem_we;

  logic [7:0]      mem_q [DEPTH_BYTES];

  logic            req;
  logic            bad_req;

  assign req     = MemRead | MemWrite;
  assign bad_req = (MemRead & MemWrite)
                 | (MemAddr[1:0] != 2'b00)
                 | (MemAddr >= 32'(DEPTH_BYTES));

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (bad_req) begin
            err_d = 1'b1;
          end else begin
            addr_d  = MemAddr[AW-1:0];
            wdata_d = MemWriteData;
            wr_d    = MemWrite;
            cnt_d   = CW'(LATENCY - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          // Access happens on the same edge that raises Mem_Done.
          state_d = IDLE;
          done_d  = 1'b1;
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            // addr_q is word-aligned, so the +1..+3 offsets never carry.
            rdata_d = {mem_q[addr_q],
                       mem_q[addr_q + AW'(1)],
                       mem_q[addr_q + AW'(2)],
                       mem_q[addr_q + AW'(3)]};
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (mem_we) begin
        // Big-endian: most significant byte at the lowest address.
        mem_q[addr_q]          <= wdata_q[31:24];
        mem_q[addr_q + AW'(1)] <= wdata_q[23:16];
        mem_q[addr_q + AW'(2)] <= wdata_q[15:8];
        mem_q[addr_q + AW'(3)] <= wdata_q[7:0];
      end
    end
  end

  assign Mem_Stall   = (state_q == BUSY);
  assign Mem_Done    = done_q;
  assign Mem_Err     = err_q;
  assign MemReadData = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_responder.sv
// ============================================================================
// Module   : tb_dm_responder
// Purpose  : Self-checking bench for dm_responder. Three instances with
//            LATENCY = 1, 2, 3 (instance k has LATENCY k+1) are exercised by
//            directed scenarios and randomized transactions, and compared
//            against a byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_responder;

  localparam int DEPTH = 128;
  localparam int NINST = 3;

  logic                   clk = 1'b0;
  logic [NINST-1:0]       rst;
  logic [NINST-1:0][31:0] addr;
  logic [NINST-1:0][31:0] wdata;
  logic [NINST-1:0]       mrd;
  logic [NINST-1:0]       mwr;
  logic [NINST-1:0][31:0] rdata;
  logic [NINST-1:0]       stall;
  logic [NINST-1:0]       done;
  logic [NINST-1:0]       err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain byte arrays plus last read value per instance
  logic [7:0]  m_mem   [NINST][DEPTH];
  logic [31:0] m_rdata [NINST];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    dm_responder #(
      .DEPTH_BYTES(DEPTH),
      .LATENCY    (g + 1)
    ) u_dut (
      .clk         (clk),
      .rst         (rst[g]),
      .MemAddr     (addr[g]),
      .MemWriteData(wdata[g]),
      .MemRead     (mrd[g]),
      .MemWrite    (mwr[g]),
      .MemReadData (rdata[g]),
      .Mem_Stall   (stall[g]),
      .Mem_Done    (done[g]),
      .Mem_Err     (err[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear(input int k);
    for (int i = 0; i < DEPTH; i++) m_mem[k][i] = 8'h00;
    m_rdata[k] = 32'h0;
  endtask

  // All outputs hold, no pulses, for n cycles
  task automatic idle_chk(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_eq("idle_rdata", rdata[k], m_rdata[k]);
      check_eq("idle_stall", {31'b0, stall[k]}, 32'd0);
      check_eq("idle_done",  {31'b0, done[k]},  32'd0);
      check_eq("idle_err",   {31'b0, err[k]},   32'd0);
    end
  endtask

  // One request on instance k; optionally scramble inputs while busy.
  task automatic do_req(input int k, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d, input bit scr);
    bit bad;
    int lat;
    int ai;
    lat = k + 1;
    @(negedge clk);
    addr[k] = a; wdata[k] = d; mrd[k] = rd; mwr[k] = wr;
    bad = (rd && wr) || (a % 4 != 0) || (a >= DEPTH);
    @(posedge clk); #1;
    if (bad) begin
      mrd[k] = 1'b0; mwr[k] = 1'b0;
      check_eq("err_pulse", {31'b0, err[k]},   32'd1);
      check_eq("err_stall", {31'b0, stall[k]}, 32'd0);
      check_eq("err_done",  {31'b0, done[k]},  32'd0);
      check_eq("err_rdata", rdata[k], m_rdata[k]);
      @(posedge clk); #1;
      check_eq("err_clear", {31'b0, err[k]},   32'd0);
      check_eq("err_stall2", {31'b0, stall[k]}, 32'd0);
    end else begin
      check_eq("acc_stall", {31'b0, stall[k]}, 32'd1);
      check_eq("acc_err",   {31'b0, err[k]},   32'd0);
      if (scr) begin
        addr[k]  = $urandom;
        wdata[k] = $urandom;
        mrd[k]   = 1'($urandom_range(0, 1));
        mwr[k]   = 1'($urandom_range(0, 1));
      end
      for (int i = 1; i < lat; i++) begin
        @(posedge clk); #1;
        check_eq("busy_stall", {31'b0, stall[k]}, 32'd1);
        check_eq("busy_done",  {31'b0, done[k]},  32'd0);
        check_eq("busy_err",   {31'b0, err[k]},   32'd0);
      end
      @(posedge clk); #1;
      ai = int'(a);
      if (wr) begin
        m_mem[k][ai]   = d[31:24];
        m_mem[k][ai+1] = d[23:16];
        m_mem[k][ai+2] = d[15:8];
        m_mem[k][ai+3] = d[7:0];
      end else begin
        m_rdata[k] = {m_mem[k][ai], m_mem[k][ai+1], m_mem[k][ai+2], m_mem[k][ai+3]};
      end
      check_eq("done_pulse", {31'b0, done[k]},  32'd1);
      check_eq("done_stall", {31'b0, stall[k]}, 32'd0);
      check_eq("done_err",   {31'b0, err[k]},   32'd0);
      check_eq("done_rdata", rdata[k], m_rdata[k]);
      mrd[k] = 1'b0; mwr[k] = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] ra;
    int          kind;
    rst = '1; addr = '0; wdata = '0; mrd = '0; mwr = '0;
    for (int k = 0; k < NINST; k++) model_clear(k);

    // 1. Reset then idle
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NINST; k++) begin
      check_eq("rst_rdata", rdata[k], 32'h0);
      check_eq("rst_stall", {31'b0, stall[k]}, 32'd0);
      check_eq("rst_done",  {31'b0, done[k]},  32'd0);
      check_eq("rst_err",   {31'b0, err[k]},   32'd0);
    end
    @(negedge clk); rst = '0;
    for (int k = 0; k < NINST; k++) idle_chk(k, 5);

    // 2. Write then read, LATENCY=2
    do_req(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    do_req(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check_eq("rd_deadbeef", rdata[1], 32'hDEADBEEF);
    check_eq("byte_0x10", {24'b0, g_dut[1].u_dut.mem_q[16]}, 32'h000000DE);

    // 3. Rejections
    do_req(1, 1'b1, 1'b0, 32'h12, 32'h0, 1'b0);
    do_req(1, 1'b0, 1'b1, 32'h80, 32'h11223344, 1'b0);
    do_req(1, 1'b1, 1'b0, 32'h7C, 32'h0, 1'b0);
    check_eq("rd_7c_prior", rdata[1], 32'h0);
    do_req(1, 1'b1, 1'b1, 32'h0, 32'h55555555, 1'b0);
    idle_chk(1, 2);

    // 4. Back-to-back, LATENCY=1, inputs scrambled while busy
    do_req(0, 1'b0, 1'b1, 32'h4, 32'h12345678, 1'b1);
    do_req(0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1);
    check_eq("b2b_rd", rdata[0], 32'h12345678);

    // 5. Reset mid-operation, LATENCY=3
    @(negedge clk);
    addr[2] = 32'h8; wdata[2] = 32'hAAAA5555; mwr[2] = 1'b1; mrd[2] = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_acc_stall", {31'b0, stall[2]}, 32'd1);
    @(posedge clk);          // first busy edge
    @(negedge clk); rst[2] = 1'b1;
    @(posedge clk); #1;      // second busy edge, reset applied
    check_eq("mid_rst_done",  {31'b0, done[2]},  32'd0);
    check_eq("mid_rst_stall", {31'b0, stall[2]}, 32'd0);
    @(negedge clk); rst[2] = 1'b0; mwr[2] = 1'b0;
    model_clear(2);
    idle_chk(2, 3);
    do_req(2, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    check_eq("mid_rd_zero", rdata[2], 32'h0);

    // 6. Boundary address
    do_req(1, 1'b0, 1'b1, 32'h7C, 32'hCAFEF00D, 1'b0);
    do_req(1, 1'b1, 1'b0, 32'h7C, 32'h0, 1'b0);
    check_eq("rd_7c", rdata[1], 32'hCAFEF00D);
    check_eq("byte_0x7f", {24'b0, g_dut[1].u_dut.mem_q[127]}, 32'h0000000D);

    // Randomized transactions on every instance
    for (int k = 0; k < NINST; k++) begin
      for (int t = 0; t < 60; t++) begin
        kind = int'($urandom_range(0, 9));
        ra = 32'($urandom_range(0, DEPTH / 4 - 1)) * 4;
        case (kind)
          0: do_req(k, 1'b1, 1'b0, ra | 32'($urandom_range(1, 3)), $urandom, 1'b0);
          1: do_req(k, 1'b0, 1'b1, 32'(DEPTH) + ra, $urandom, 1'b0);
          2: do_req(k, 1'b1, 1'b1, ra, $urandom, 1'b0);
          default: begin
            if ($urandom_range(0, 1) == 0)
              do_req(k, 1'b0, 1'b1, ra, $urandom, 1'($urandom_range(0, 1)));
            else
              do_req(k, 1'b1, 1'b0, ra, 32'h0, 1'($urandom_range(0, 1)));
          end
        endcase
        idle_chk(k, int'($urandom_range(0, 2)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
